alu_exec_sequencer: RTL and testbench

- Execute-stage controller that accepts one decoded RV32I instruction per handshake and selects operands by opcode (reg/reg, reg/imm, LUI, AUIPC, load/store address).
- Single-cycle ops complete in one cycle; shifts run iteratively at STEP bits per cycle.
- Sits between decode and writeback/memory stage, with valid/ready on both sides.

---
 rtl/alu_exec_sequencer_if.sv | 38 +++
 rtl/alu_exec_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_sequencer_if.sv
// Decode-to-execute and execute-to-writeback handshake bundle for alu_exec_sequencer.
interface alu_exec_sequencer_if;
    localparam int unsigned XLEN = 32;

    // Request side: one decoded instruction per in_valid & in_ready
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   pc;
    logic [11:0]       imm12;
    logic [19:0]       u_imm20;
    logic [4:0]        rs2;

    // Response side: result held until out_ready
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   result;
    logic              err;
    logic              busy;

    // Decode / downstream side
    modport master (
        output in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data,
               pc, imm12, u_imm20, rs2, out_ready,
        input  in_ready, out_valid, result, err, busy
    );

    // Execute sequencer side
    modport slave (
        input  in_valid, opcode, funct3, funct7_5, rs1_data, rs2_data,
               pc, imm12, u_imm20, rs2, out_ready,
        output in_ready, out_valid, result, err, busy
    );
endinterface

// File: rtl/alu_exec_sequencer.sv
// RV32I execute-stage sequencer: single-cycle ALU ops, iterative shifter
// (STEP bits per cycle), result held in DONE until accepted downstream.
module alu_exec_sequencer #(
    parameter int unsigned STEP = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_exec_sequencer_if.slave   bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    logic [1:0]        state, state_next;
    logic [XLEN-1:0]   work, work_next;
    logic [CNT_W-1:0]  rem, rem_next;
    logic              shl, shl_next;
    logic              sra, sra_next;
    logic [XLEN-1:0]   result_q, result_next;
    logic              err_q, err_next;
    logic              in_ready_q, out_valid_q, busy_q;

    logic [XLEN-1:0]   imm_sext;
    logic [XLEN-1:0]   u_value;
    logic [XLEN-1:0]   op1, op2;
    logic [4:0]        shamt;
    logic              is_reg;
    logic [XLEN-1:0]   dec_result;
    logic              dec_err;
    logic              dec_shift;
    logic              dec_shl;
    logic              dec_sra;

    logic [CNT_W-1:0]  step_amt;
    logic [XLEN-1:0]   shifted;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;

    // Operand selection and single-cycle ALU evaluation on the presented instruction
    always_comb begin
        is_reg     = (bus.opcode == OP_REG);
        imm_sext   = {{(XLEN-12){bus.imm12[11]}}, bus.imm12};
        u_value    = {bus.u_imm20, 12'b0};
        op1        = bus.rs1_data;
        op2        = is_reg ? bus.rs2_data : imm_sext;
        shamt      = is_reg ? bus.rs2_data[4:0] : bus.rs2;
        dec_result = '0;
        dec_err    = 1'b0;
        dec_shift  = 1'b0;
        dec_shl    = 1'b0;
        dec_sra    = 1'b0;
        case (bus.opcode)
            OP_IMM, OP_REG: begin
                case (bus.funct3)
                    3'b000:  dec_result = (is_reg && bus.funct7_5) ? op1 - op2 : op1 + op2;
                    3'b010:  dec_result = {31'b0, ($signed(op1) < $signed(op2))};
                    3'b011:  dec_result = {31'b0, (op1 < op2)};
                    3'b100:  dec_result = op1 ^ op2;
                    3'b110:  dec_result = op1 | op2;
                    3'b111:  dec_result = op1 & op2;
                    3'b001: begin
                        dec_shift  = 1'b1;
                        dec_shl    = 1'b1;
                        dec_result = op1;
                    end
                    3'b101: begin
                        dec_shift  = 1'b1;
                        dec_sra    = bus.funct7_5;
                        dec_result = op1;
                    end
                    default: dec_result = '0;
                endcase
            end
            OP_LOAD, OP_STORE: dec_result = bus.rs1_data + imm_sext;
            OP_LUI:            dec_result = u_value;
            OP_AUIPC:          dec_result = bus.pc + u_value;
            default: begin
                dec_result = '0;
                dec_err    = 1'b1;
            end
        endcase
    end

    // One shifter step: at most STEP bits, never past the remaining count
    always_comb begin
        step_amt = (rem < STEP_C) ? rem : STEP_C;
        if (shl) begin
            shifted = work << step_amt;
        end else if (sra) begin
            shifted = XLEN'($signed(work) >>> step_amt);
        end else begin
            shifted = work >> step_amt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next  = state;
        work_next   = work;
        rem_next    = rem;
        shl_next    = shl;
        sra_next    = sra;
        result_next = result_q;
        err_next    = err_q;
        case (state)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    if (dec_shift && (shamt != 5'd0)) begin
                        work_next  = op1;
                        rem_next   = CNT_W'(shamt);
                        shl_next   = dec_shl;
                        sra_next   = dec_sra;
                        state_next = S_SHIFT;
                    end else begin
                        result_next = dec_result;
                        err_next    = dec_err;
                        state_next  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                work_next = shifted;
                rem_next  = rem - step_amt;
                if (rem == step_amt) begin
                    result_next = shifted;
                    err_next    = 1'b0;
                    state_next  = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            work        <= '0;
            rem         <= '0;
            shl         <= 1'b0;
            sra         <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_next;
            work        <= work_next;
            rem         <= rem_next;
            shl         <= shl_next;
            sra         <= sra_next;
            result_q    <= result_next;
            err_q       <= err_next;
            in_ready_q  <= (state_next == S_IDLE);
            out_valid_q <= (state_next == S_DONE);
            busy_q      <= (state_next == S_SHIFT);
        end
    end
endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer: one STEP=1 and one STEP=8 instance.
module tb_alu_exec_sequencer;
    logic clk;
    logic rst;
    logic sel;   // 0: STEP=1 instance, 1: STEP=8 instance

    logic        d_in_valid;
    logic [6:0]  d_opcode;
    logic [2:0]  d_funct3;
    logic        d_funct7_5;
    logic [31:0] d_rs1_data;
    logic [31:0] d_rs2_data;
    logic [31:0] d_pc;
    logic [11:0] d_imm12;
    logic [19:0] d_u_imm20;
    logic [4:0]  d_rs2;
    logic        d_out_ready;

    int n_cmp;
    int n_err;

    alu_exec_sequencer_if if1();
    alu_exec_sequencer_if if8();

    alu_exec_sequencer #(.STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    alu_exec_sequencer #(.STEP(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

    assign if1.in_valid  = d_in_valid & ~sel;
    assign if8.in_valid  = d_in_valid & sel;
    assign if1.opcode    = d_opcode;    assign if8.opcode    = d_opcode;
    assign if1.funct3    = d_funct3;    assign if8.funct3    = d_funct3;
    assign if1.funct7_5  = d_funct7_5;  assign if8.funct7_5  = d_funct7_5;
    assign if1.rs1_data  = d_rs1_data;  assign if8.rs1_data  = d_rs1_data;
    assign if1.rs2_data  = d_rs2_data;  assign if8.rs2_data  = d_rs2_data;
    assign if1.pc        = d_pc;        assign if8.pc        = d_pc;
    assign if1.imm12     = d_imm12;     assign if8.imm12     = d_imm12;
    assign if1.u_imm20   = d_u_imm20;   assign if8.u_imm20   = d_u_imm20;
    assign if1.rs2       = d_rs2;       assign if8.rs2       = d_rs2;
    assign if1.out_ready = d_out_ready; assign if8.out_ready = d_out_ready;

    wire        o_in_ready  = sel ? if8.in_ready  : if1.in_ready;
    wire        o_out_valid = sel ? if8.out_valid : if1.out_valid;
    wire [31:0] o_result    = sel ? if8.result    : if1.result;
    wire        o_err       = sel ? if8.err       : if1.err;
    wire        o_busy      = sel ? if8.busy      : if1.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one instruction at a negedge, scramble inputs after the handshake,
    // then measure latency / busy cycles and check the held result.
    task automatic do_op(input string tag, input logic s, input logic [6:0] opc,
                         input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [11:0] imm,
                         input logic [19:0] u, input logic [4:0] sh,
                         input logic [31:0] exp_res, input logic exp_err,
                         input int exp_lat, input int exp_busy);
        int lat;
        int nbusy;
        sel = s;
        d_opcode = opc; d_funct3 = f3; d_funct7_5 = f7;
        d_rs1_data = a; d_rs2_data = b; d_pc = p;
        d_imm12 = imm; d_u_imm20 = u; d_rs2 = sh;
        d_out_ready = 1'b1;
        check({tag, ".in_ready"}, 32'(o_in_ready), 32'd1);
        d_in_valid = 1'b1;
        @(negedge clk);
        d_in_valid = 1'b0;
        d_opcode = 7'h7F; d_rs1_data = ~a; d_rs2_data = ~b; d_pc = ~p;
        d_imm12 = ~imm; d_u_imm20 = ~u; d_rs2 = ~sh; d_funct7_5 = ~f7;
        lat = 1;
        nbusy = 0;
        while (!o_out_valid && lat < 100) begin
            if (o_busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".busy_cycles"}, 32'(nbusy), 32'(exp_busy));
        check({tag, ".result"}, o_result, exp_res);
        check({tag, ".err"}, 32'(o_err), 32'(exp_err));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        sel = 1'b0;
        d_in_valid = 1'b0; d_opcode = '0; d_funct3 = '0; d_funct7_5 = 1'b0;
        d_rs1_data = '0; d_rs2_data = '0; d_pc = '0; d_imm12 = '0;
        d_u_imm20 = '0; d_rs2 = '0; d_out_ready = 1'b1;

        // Reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.out_valid", 32'(o_out_valid), 32'd0);
        check("rst.result", o_result, 32'd0);
        check("rst.err", 32'(o_err), 32'd0);
        check("rst.busy", 32'(o_busy), 32'd0);
        check("rst.in_ready", 32'(o_in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle ALU ops on the STEP=1 instance
        do_op("addi",  1'b0, 7'b0010011, 3'b000, 1'b0, 32'd5, 32'd0, 32'd0, 12'hFFF, 20'h0, 5'd0, 32'h0000_0004, 1'b0, 1, 0);
        do_op("addi_f7", 1'b0, 7'b0010011, 3'b000, 1'b1, 32'd10, 32'd0, 32'd0, 12'h003, 20'h0, 5'd0, 32'h0000_000D, 1'b0, 1, 0);
        do_op("sub",   1'b0, 7'b0110011, 3'b000, 1'b1, 32'h1, 32'h2, 32'd0, 12'h0, 20'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1, 0);
        do_op("sltu",  1'b0, 7'b0110011, 3'b011, 1'b0, 32'h1, 32'h2, 32'd0, 12'h0, 20'h0, 5'd0, 32'h0000_0001, 1'b0, 1, 0);
        do_op("sltu_r", 1'b0, 7'b0110011, 3'b011, 1'b0, 32'h8000_0000, 32'h0, 32'd0, 12'h0, 20'h0, 5'd0, 32'h0000_0000, 1'b0, 1, 0);
        do_op("slt",   1'b0, 7'b0110011, 3'b010, 1'b0, 32'h8000_0000, 32'h0, 32'd0, 12'h0, 20'h0, 5'd0, 32'h0000_0001, 1'b0, 1, 0);
        do_op("xor",   1'b0, 7'b0110011, 3'b100, 1'b0, 32'hF0F0_00FF, 32'h0F0F_0F0F, 32'd0, 12'h0, 20'h0, 5'd0, 32'hFFFF_0FF0, 1'b0, 1, 0);
        do_op("or",    1'b0, 7'b0110011, 3'b110, 1'b0, 32'hF0F0_00FF, 32'h0F0F_0F0F, 32'd0, 12'h0, 20'h0, 5'd0, 32'hFFFF_0FFF, 1'b0, 1, 0);
        do_op("and",   1'b0, 7'b0110011, 3'b111, 1'b0, 32'hF0F0_00FF, 32'h0F0F_0F0F, 32'd0, 12'h0, 20'h0, 5'd0, 32'h0000_000F, 1'b0, 1, 0);
        do_op("auipc", 1'b0, 7'b0010111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h0000_1000, 12'h0, 20'h12345, 5'd0, 32'h1234_6000, 1'b0, 1, 0);
        do_op("lui",   1'b0, 7'b0110111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h0000_1000, 12'h0, 20'h12345, 5'd0, 32'h1234_5000, 1'b0, 1, 0);
        do_op("load",  1'b0, 7'b0000011, 3'b010, 1'b0, 32'h100, 32'd0, 32'd0, 12'hFFC, 20'h0, 5'd0, 32'h0000_00FC, 1'b0, 1, 0);
        do_op("store", 1'b0, 7'b0100011, 3'b010, 1'b0, 32'h100, 32'd0, 32'd0, 12'h004, 20'h0, 5'd0, 32'h0000_0104, 1'b0, 1, 0);

        // Iterative shifts: latency 1 + ceil(k/STEP)
        do_op("srai_s1", 1'b0, 7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd0, 12'h0, 20'h0, 5'd31, 32'hFFFF_FFFF, 1'b0, 32, 31);
        do_op("srai_s8", 1'b1, 7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd0, 12'h0, 20'h0, 5'd31, 32'hFFFF_FFFF, 1'b0, 5, 4);
        do_op("srai_k0", 1'b0, 7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd0, 12'h0, 20'h0, 5'd0, 32'h8000_0000, 1'b0, 1, 0);
        do_op("slli_s1", 1'b0, 7'b0010011, 3'b001, 1'b0, 32'h1, 32'd0, 32'd0, 12'h0, 20'h0, 5'd3, 32'h0000_0008, 1'b0, 4, 3);
        do_op("srl_s8",  1'b1, 7'b0110011, 3'b101, 1'b0, 32'h8000_0000, 32'hFFFF_FFE4, 32'd0, 12'h0, 20'h0, 5'd0, 32'h0800_0000, 1'b0, 2, 1);
        do_op("sra_s8",  1'b1, 7'b0110011, 3'b101, 1'b1, 32'h8765_4321, 32'h0000_000C, 32'd0, 12'h0, 20'h0, 5'd0, 32'hFFF8_7654, 1'b0, 3, 2);

        // Backpressure: DONE held with out_ready low
        sel = 1'b0;
        d_opcode = 7'b0010011; d_funct3 = 3'b000; d_funct7_5 = 1'b0;
        d_rs1_data = 32'd7; d_imm12 = 12'h001; d_out_ready = 1'b0;
        d_in_valid = 1'b1;
        @(negedge clk);
        d_rs1_data = 32'd100;
        for (int i = 0; i < 3; i++) begin
            check("bp.out_valid", 32'(o_out_valid), 32'd1);
            check("bp.result", o_result, 32'd8);
            check("bp.in_ready", 32'(o_in_ready), 32'd0);
            @(negedge clk);
        end
        d_in_valid = 1'b0;
        d_out_ready = 1'b1;
        @(negedge clk);
        check("bp.release_out_valid", 32'(o_out_valid), 32'd0);
        check("bp.release_in_ready", 32'(o_in_ready), 32'd1);

        // Reset while shifting (STEP=1, k=31), ten cycles in
        d_opcode = 7'b0010011; d_funct3 = 3'b101; d_funct7_5 = 1'b1;
        d_rs1_data = 32'h8000_0000; d_rs2 = 5'd31;
        d_in_valid = 1'b1;
        @(negedge clk);
        d_in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid.busy_before", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid.out_valid", 32'(o_out_valid), 32'd0);
        check("mid.busy", 32'(o_busy), 32'd0);
        check("mid.result", o_result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op("bad_op", 1'b0, 7'h7F, 3'b000, 1'b0, 32'h1234, 32'h5678, 32'h1000, 12'h123, 20'h1, 5'd1, 32'h0000_0000, 1'b1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
